// File: rtl/writeback_stage.sv
// Writeback pipeline stage: WB register, result select, register-file write
// port, retired-instruction counter.
// Optional WB->ID bypass ports are built only when WB_BYPASS_EN is defined.
module writeback_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic        m_valid,
    input  logic        m_reg_write,
    input  logic [4:0]  m_rd,
    input  logic [1:0]  m_result_src,
    input  logic [31:0] m_alu_result,
    input  logic [31:0] m_read_data,
    input  logic [31:0] m_pc_plus4,
    input  logic [31:0] m_imm_ext,
    output logic [4:0]  A3,
    output logic [31:0] WD3,
    output logic        WE3,
    output logic        wb_valid,
    output logic [31:0] retire_count
`ifdef WB_BYPASS_EN
    ,
    input  logic [4:0]  rs1_addr,
    input  logic [4:0]  rs2_addr,
    output logic        fwd1_hit,
    output logic        fwd2_hit,
    output logic [31:0] fwd_data
`endif
);

    localparam int unsigned XLEN  = 32;
    localparam int unsigned REG_W = 5;

    logic             valid_q,     valid_d;
    logic             reg_write_q, reg_write_d;
    logic [REG_W-1:0] rd_q,        rd_d;
    logic [XLEN-1:0]  wd_q,        wd_d;
    logic [XLEN-1:0]  retire_count_q, retire_count_d;
    logic [XLEN-1:0]  result_sel;

    // Result mux evaluated at capture time so WD3 comes straight from a flop
    always_comb begin
        result_sel = m_alu_result;
        case (m_result_src)
            2'b00:   result_sel = m_alu_result;
            2'b01:   result_sel = m_read_data;
            2'b10:   result_sel = m_pc_plus4;
            default: result_sel = m_imm_ext;
        endcase
    end

    // Next-state: flush kills the incoming entry, stall holds, otherwise capture;
    // the outgoing valid entry retires whenever it leaves (no stall, or flushed)
    always_comb begin
        valid_d        = valid_q;
        reg_write_d    = reg_write_q;
        rd_d           = rd_q;
        wd_d           = wd_q;
        retire_count_d = retire_count_q;

        if (flush) begin
            valid_d = 1'b0;
        end else if (!stall) begin
            valid_d     = m_valid;
            reg_write_d = m_reg_write;
            rd_d        = m_rd;
            wd_d        = result_sel;
        end

        if (valid_q && (!stall || flush)) begin
            retire_count_d = retire_count_q + XLEN'(1);
        end
    end

    // WB register and counter, synchronous reset has top priority
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q        <= 1'b0;
            reg_write_q    <= 1'b0;
            rd_q           <= '0;
            wd_q           <= '0;
            retire_count_q <= '0;
        end else begin
            valid_q        <= valid_d;
            reg_write_q    <= reg_write_d;
            rd_q           <= rd_d;
            wd_q           <= wd_d;
            retire_count_q <= retire_count_d;
        end
    end

    // Register-file write port; x0 is never written
    always_comb begin
        A3           = rd_q;
        WD3          = wd_q;
        WE3          = valid_q & reg_write_q & (rd_q != '0);
        wb_valid     = valid_q;
        retire_count = retire_count_q;
    end

`ifdef WB_BYPASS_EN
    // Forwarding of the in-flight write to the decode-stage source operands
    always_comb begin
        fwd1_hit = WE3 & (rs1_addr == A3);
        fwd2_hit = WE3 & (rs2_addr == A3);
        fwd_data = WD3;
    end
`endif

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage.
// Define WB_BYPASS_EN at compile time to also exercise the bypass ports.
module tb_writeback_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        m_valid;
    logic        m_reg_write;
    logic [4:0]  m_rd;
    logic [1:0]  m_result_src;
    logic [31:0] m_alu_result;
    logic [31:0] m_read_data;
    logic [31:0] m_pc_plus4;
    logic [31:0] m_imm_ext;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        WE3;
    logic        wb_valid;
    logic [31:0] retire_count;
`ifdef WB_BYPASS_EN
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        fwd1_hit;
    logic        fwd2_hit;
    logic [31:0] fwd_data;
`endif

    int errors = 0;
    int checks = 0;

    writeback_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .m_valid      (m_valid),
        .m_reg_write  (m_reg_write),
        .m_rd         (m_rd),
        .m_result_src (m_result_src),
        .m_alu_result (m_alu_result),
        .m_read_data  (m_read_data),
        .m_pc_plus4   (m_pc_plus4),
        .m_imm_ext    (m_imm_ext),
        .A3           (A3),
        .WD3          (WD3),
        .WE3          (WE3),
        .wb_valid     (wb_valid),
        .retire_count (retire_count)
`ifdef WB_BYPASS_EN
        ,
        .rs1_addr     (rs1_addr),
        .rs2_addr     (rs2_addr),
        .fwd1_hit     (fwd1_hit),
        .fwd2_hit     (fwd2_hit),
        .fwd_data     (fwd_data)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge, then settle before sampling / driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_m(input logic v, input logic rw, input logic [4:0] rd,
                           input logic [1:0] src, input logic [31:0] alu,
                           input logic [31:0] rdata, input logic [31:0] pc4,
                           input logic [31:0] imm);
        m_valid = v; m_reg_write = rw; m_rd = rd; m_result_src = src;
        m_alu_result = alu; m_read_data = rdata; m_pc_plus4 = pc4; m_imm_ext = imm;
    endtask

    task automatic bubble();
        drive_m(1'b0, 1'b0, 5'd0, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        drive_m(1'b1, 1'b1, 5'd7, 2'b00, 32'h1111, 32'h0, 32'h0, 32'h0);
        step();
        reset = 1'b0;
        bubble();
        checks++; if (A3 !== 5'd0) begin errors++; $display("FAIL reset_a3: got %0d exp 0", A3); end
        checks++; if (WD3 !== 32'h0) begin errors++; $display("FAIL reset_wd3: got %h exp 0", WD3); end
        checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL reset_we3: got %b exp 0", WE3); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", wb_valid); end
        checks++; if (retire_count !== 32'h0) begin errors++; $display("FAIL reset_count: got %h exp 0", retire_count); end
`ifdef WB_BYPASS_EN
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        #1;
        checks++; if (fwd1_hit !== 1'b0 || fwd2_hit !== 1'b0 || fwd_data !== 32'h0) begin
            errors++; $display("FAIL reset_fwd: got %b %b %h exp 0 0 0", fwd1_hit, fwd2_hit, fwd_data); end
`endif
    endtask

    task automatic test_basic();
        drive_m(1'b1, 1'b1, 5'd5, 2'b00, 32'h0000_002A, 32'hAAAA, 32'hBBBB, 32'hCCCC);
        step();
        bubble();
        checks++; if (A3 !== 5'd5) begin errors++; $display("FAIL basic_a3: got %0d exp 5", A3); end
        checks++; if (WD3 !== 32'h2A) begin errors++; $display("FAIL basic_wd3: got %h exp 2a", WD3); end
        checks++; if (WE3 !== 1'b1) begin errors++; $display("FAIL basic_we3: got %b exp 1", WE3); end
        checks++; if (retire_count !== 32'd0) begin errors++; $display("FAIL basic_count0: got %0d exp 0", retire_count); end
        step();
        checks++; if (retire_count !== 32'd1) begin errors++; $display("FAIL basic_count1: got %0d exp 1", retire_count); end
        checks++; if (wb_valid !== 1'b0 || WE3 !== 1'b0) begin errors++; $display("FAIL basic_bubble: got %b %b exp 0 0", wb_valid, WE3); end
    endtask

    task automatic test_x0();
        drive_m(1'b1, 1'b1, 5'd0, 2'b01, 32'h1, 32'hDEAD_BEEF, 32'h2, 32'h3);
        step();
        bubble();
        checks++; if (WE3 !== 1'b0) begin errors++; $display("FAIL x0_we3: got %b exp 0", WE3); end
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL x0_valid: got %b exp 1", wb_valid); end
        checks++; if (WD3 !== 32'hDEAD_BEEF) begin errors++; $display("FAIL x0_wd3: got %h exp deadbeef", WD3); end
        step();
        checks++; if (retire_count !== 32'd2) begin errors++; $display("FAIL x0_count: got %0d exp 2", retire_count); end
    endtask

    task automatic test_imm_src();
        drive_m(1'b1, 1'b1, 5'd11, 2'b11, 32'h1, 32'h2, 32'h3, 32'hFFFF_F800);
        step();
        bubble();
        checks++; if (WD3 !== 32'hFFFF_F800 || WE3 !== 1'b1) begin
            errors++; $display("FAIL imm_src: got %h %b exp fffff800 1", WD3, WE3); end
        step();
        checks++; if (retire_count !== 32'd3) begin errors++; $display("FAIL imm_count: got %0d exp 3", retire_count); end
    endtask

    task automatic test_stall();
        drive_m(1'b1, 1'b1, 5'd9, 2'b10, 32'h1, 32'h2, 32'h0000_0104, 32'h3);
        step();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_m(1'b1, 1'b1, 5'(7 + i), 2'b00, 32'h5000 + 32'(i), 32'h0, 32'h0, 32'h0);
            step();
            checks++; if (A3 !== 5'd9 || WD3 !== 32'h104 || WE3 !== 1'b1) begin
                errors++; $display("FAIL stall_hold%0d: got %0d %h %b exp 9 104 1", i, A3, WD3, WE3); end
            checks++; if (retire_count !== 32'd3) begin
                errors++; $display("FAIL stall_count%0d: got %0d exp 3", i, retire_count); end
        end
        stall = 1'b0;
        bubble();
        step();
        checks++; if (retire_count !== 32'd4 || wb_valid !== 1'b0) begin
            errors++; $display("FAIL stall_release: got %0d %b exp 4 0", retire_count, wb_valid); end
    endtask

    task automatic test_flush();
        drive_m(1'b1, 1'b1, 5'd3, 2'b00, 32'h33, 32'h0, 32'h0, 32'h0);
        step();
        checks++; if (WE3 !== 1'b1 || A3 !== 5'd3) begin errors++; $display("FAIL flush_load: got %b %0d exp 1 3", WE3, A3); end
        stall = 1'b1; flush = 1'b1;
        drive_m(1'b1, 1'b1, 5'd4, 2'b00, 32'h44, 32'h0, 32'h0, 32'h0);
        step();
        stall = 1'b0; flush = 1'b0;
        bubble();
        checks++; if (wb_valid !== 1'b0 || WE3 !== 1'b0) begin errors++; $display("FAIL flush_kill: got %b %b exp 0 0", wb_valid, WE3); end
        checks++; if (retire_count !== 32'd5) begin errors++; $display("FAIL flush_count: got %0d exp 5", retire_count); end
        step();
        checks++; if (retire_count !== 32'd5) begin errors++; $display("FAIL flush_nocount: got %0d exp 5", retire_count); end
    endtask

    task automatic test_bubble();
        drive_m(1'b0, 1'b1, 5'd6, 2'b00, 32'h66, 32'h0, 32'h0, 32'h0);
        step();
        bubble();
        checks++; if (WE3 !== 1'b0 || wb_valid !== 1'b0) begin errors++; $display("FAIL bubble_we3: got %b %b exp 0 0", WE3, wb_valid); end
        step();
        checks++; if (retire_count !== 32'd5) begin errors++; $display("FAIL bubble_count: got %0d exp 5", retire_count); end
    endtask

    task automatic test_wrap_reset();
        drive_m(1'b1, 1'b1, 5'd8, 2'b00, 32'h88, 32'h0, 32'h0, 32'h0);
        step();
        bubble();
        force dut.retire_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.retire_count_q;
        #1;
        checks++; if (retire_count !== 32'hFFFF_FFFF) begin errors++; $display("FAIL wrap_preload: got %h exp ffffffff", retire_count); end
        step();
        checks++; if (retire_count !== 32'h0) begin errors++; $display("FAIL wrap_zero: got %h exp 0", retire_count); end
        drive_m(1'b1, 1'b1, 5'd12, 2'b00, 32'h55, 32'h0, 32'h0, 32'h0);
        step();
        stall = 1'b1;
        step();
        checks++; if (WE3 !== 1'b1 || retire_count !== 32'h0) begin
            errors++; $display("FAIL pre_reset: got %b %h exp 1 0", WE3, retire_count); end
        reset = 1'b1;
        step();
        reset = 1'b0; stall = 1'b0;
        bubble();
        checks++; if (A3 !== 5'd0 || WD3 !== 32'h0 || WE3 !== 1'b0 || wb_valid !== 1'b0 || retire_count !== 32'h0) begin
            errors++; $display("FAIL midreset: got %0d %h %b %b %h exp all 0", A3, WD3, WE3, wb_valid, retire_count); end
        step();
        checks++; if (retire_count !== 32'h0) begin errors++; $display("FAIL midreset_count: got %h exp 0", retire_count); end
    endtask

`ifdef WB_BYPASS_EN
    task automatic test_bypass();
        drive_m(1'b1, 1'b1, 5'd18, 2'b00, 32'h0000_0002, 32'h0, 32'h0, 32'h0);
        step();
        bubble();
        rs1_addr = 5'd18; rs2_addr = 5'd4;
        #1;
        checks++; if (fwd1_hit !== 1'b1 || fwd2_hit !== 1'b0 || fwd_data !== 32'h2) begin
            errors++; $display("FAIL bypass_hit: got %b %b %h exp 1 0 2", fwd1_hit, fwd2_hit, fwd_data); end
        drive_m(1'b1, 1'b1, 5'd0, 2'b00, 32'h0000_0002, 32'h0, 32'h0, 32'h0);
        step();
        bubble();
        rs1_addr = 5'd0; rs2_addr = 5'd0;
        #1;
        checks++; if (fwd1_hit !== 1'b0 || fwd2_hit !== 1'b0) begin
            errors++; $display("FAIL bypass_x0: got %b %b exp 0 0", fwd1_hit, fwd2_hit); end
        step();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_x0();
        test_imm_src();
        test_stall();
        test_flush();
        test_bubble();
        test_wrap_reset();
`ifdef WB_BYPASS_EN
        test_bypass();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
